// File: rtl/shift_double_counter.sv
// Registered shift/rotate/saturating-double datapath with a saturating, clearable
// count of executed operations. All outputs are flops updated only when in_valid=1.
module shift_double_counter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned STEP      = 1,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     data_in,
  input  logic [2:0]           control,
  output logic [WIDTH-1:0]     data_out,
  output logic                 carry_out,
  output logic [CNT_WIDTH-1:0] op_count,
  output logic                 cnt_sat
);

  typedef enum logic [2:0] {
    OpHold   = 3'b000,
    OpLoad   = 3'b001,
    OpShl    = 3'b010,
    OpShr    = 3'b011,
    OpRol    = 3'b100,
    OpRor    = 3'b101,
    OpDouble = 3'b110,
    OpClear  = 3'b111
  } op_e;

  localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]     data_d;
  logic                 carry_d;
  logic [CNT_WIDTH-1:0] count_d;
  logic                 count_inc;
  logic                 count_clr;
  logic [WIDTH-1:0]     rol_val;
  logic [WIDTH-1:0]     ror_val;

  assign rol_val = (data_out << STEP) | (data_out >> (WIDTH - STEP));
  assign ror_val = (data_out >> STEP) | (data_out << (WIDTH - STEP));

  always_comb begin
    data_d    = data_out;
    carry_d   = carry_out;
    count_inc = 1'b0;
    count_clr = 1'b0;
    case (op_e'(control))
      OpHold: ;
      OpLoad: begin
        data_d    = data_in;
        carry_d   = 1'b0;
        count_inc = 1'b1;
      end
      OpShl: begin
        data_d    = data_out << STEP;
        carry_d   = |data_out[WIDTH-1 -: STEP];
        count_inc = 1'b1;
      end
      OpShr: begin
        data_d    = data_out >> STEP;
        carry_d   = |data_out[STEP-1:0];
        count_inc = 1'b1;
      end
      OpRol: begin
        data_d    = rol_val;
        carry_d   = rol_val[0];
        count_inc = 1'b1;
      end
      OpRor: begin
        data_d    = ror_val;
        carry_d   = ror_val[WIDTH-1];
        count_inc = 1'b1;
      end
      OpDouble: begin
        // Doubling a value with the MSB set overflows, so clamp to all ones.
        if (data_out[WIDTH-1]) begin
          data_d  = '1;
          carry_d = 1'b1;
        end else begin
          data_d  = data_out << 1;
          carry_d = 1'b0;
        end
        count_inc = 1'b1;
      end
      OpClear: begin
        data_d    = '0;
        carry_d   = 1'b0;
        count_clr = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    count_d = op_count;
    if (count_clr) begin
      count_d = '0;
    end else if (count_inc && !cnt_sat) begin
      count_d = op_count + CntOne;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= '0;
      carry_out <= 1'b0;
      op_count  <= '0;
      cnt_sat   <= 1'b0;
    end else if (in_valid) begin
      data_out  <= data_d;
      carry_out <= carry_d;
      op_count  <= count_d;
      // Registered alongside op_count so it flags max in the same cycle.
      cnt_sat   <= (count_d == {CNT_WIDTH{1'b1}});
    end
  end

endmodule

// File: tb/tb_shift_double_counter.sv
// Directed checks on a small (4-bit data, 3-bit count) instance plus a random soak
// of a default-parameter instance against a bit-level reference model.
module tb_shift_double_counter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Small instance: WIDTH=4, STEP=1, CNT_WIDTH=3.
  logic       a_valid;
  logic [3:0] a_din;
  logic [2:0] a_ctl;
  logic [3:0] a_dout;
  logic       a_carry;
  logic [2:0] a_cnt;
  logic       a_sat;

  // Default instance: WIDTH=8, STEP=1, CNT_WIDTH=8.
  logic       b_valid;
  logic [7:0] b_din;
  logic [2:0] b_ctl;
  logic [7:0] b_dout;
  logic       b_carry;
  logic [7:0] b_cnt;
  logic       b_sat;

  shift_double_counter #(.WIDTH(4), .STEP(1), .CNT_WIDTH(3)) u_small (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_valid),
    .data_in   (a_din),
    .control   (a_ctl),
    .data_out  (a_dout),
    .carry_out (a_carry),
    .op_count  (a_cnt),
    .cnt_sat   (a_sat)
  );

  shift_double_counter u_dflt (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_valid),
    .data_in   (b_din),
    .control   (b_ctl),
    .data_out  (b_dout),
    .carry_out (b_carry),
    .op_count  (b_cnt),
    .cnt_sat   (b_sat)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic a_op(input logic v, input logic [2:0] c, input logic [3:0] d);
    @(negedge clk);
    a_valid = v;
    a_ctl   = c;
    a_din   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic a_expect(input string tag, input logic [3:0] d, input logic c,
                          input logic [2:0] n, input logic s);
    check_eq({tag, ".data"}, 32'(a_dout), 32'(d));
    check_eq({tag, ".carry"}, 32'(a_carry), 32'(c));
    check_eq({tag, ".count"}, 32'(a_cnt), 32'(n));
    check_eq({tag, ".sat"}, 32'(a_sat), 32'(s));
  endtask

  // Reference model for the 8-bit, STEP=1 instance, written bit-by-bit.
  logic [7:0] m_data;
  logic       m_carry;
  logic [7:0] m_cnt;

  task automatic model_step(input logic [2:0] c, input logic [7:0] d);
    logic [7:0] r;
    logic [7:0] nr;
    r  = m_data;
    nr = r;
    if (c >= 3'd1 && c <= 3'd6 && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    case (c)
      3'd1: begin nr = d; m_carry = 1'b0; end
      3'd2: begin for (int i = 1; i < 8; i++) nr[i] = r[i-1]; nr[0] = 1'b0; m_carry = r[7]; end
      3'd3: begin for (int i = 0; i < 7; i++) nr[i] = r[i+1]; nr[7] = 1'b0; m_carry = r[0]; end
      3'd4: begin for (int i = 0; i < 8; i++) nr[(i+1)%8] = r[i]; m_carry = nr[0]; end
      3'd5: begin for (int i = 0; i < 8; i++) nr[i] = r[(i+1)%8]; m_carry = nr[7]; end
      3'd6: begin
        if (r[7]) begin nr = 8'hFF; m_carry = 1'b1; end
        else begin nr = r * 8'd2; m_carry = 1'b0; end
      end
      3'd7: begin nr = 8'h00; m_carry = 1'b0; m_cnt = 8'h00; end
      default: ;
    endcase
    m_data = nr;
  endtask

  initial begin
    a_valid = 1'b0; a_ctl = 3'd0; a_din = 4'h0;
    b_valid = 1'b0; b_ctl = 3'd0; b_din = 8'h00;

    // Asynchronous reset mid-cycle, checked before any clock edge.
    #7 rst_n = 1'b0;
    #1;
    a_expect("async_rst", 4'h0, 1'b0, 3'd0, 1'b0);
    check_eq("async_rst.b_data", 32'(b_dout), 32'h0);
    check_eq("async_rst.b_count", 32'(b_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    a_op(1'b1, 3'b001, 4'b1011); a_expect("load", 4'b1011, 1'b0, 3'd1, 1'b0);
    a_op(1'b1, 3'b010, 4'h0);    a_expect("shl",  4'b0110, 1'b1, 3'd2, 1'b0);
    a_op(1'b1, 3'b011, 4'h0);    a_expect("shr",  4'b0011, 1'b0, 3'd3, 1'b0);
    a_op(1'b1, 3'b100, 4'h0);    a_expect("rol",  4'b0110, 1'b0, 3'd4, 1'b0);
    a_op(1'b1, 3'b101, 4'h0);    a_expect("ror",  4'b0011, 1'b0, 3'd5, 1'b0);
    a_op(1'b1, 3'b111, 4'h0);    a_expect("clr1", 4'b0000, 1'b0, 3'd0, 1'b0);

    a_op(1'b1, 3'b001, 4'b0101); a_expect("load2", 4'b0101, 1'b0, 3'd1, 1'b0);
    a_op(1'b1, 3'b110, 4'h0);    a_expect("dbl1",  4'b1010, 1'b0, 3'd2, 1'b0);
    a_op(1'b1, 3'b110, 4'h0);    a_expect("dbl2",  4'b1111, 1'b1, 3'd3, 1'b0);

    // SHL presented without in_valid must leave everything alone.
    for (int i = 0; i < 5; i++) a_op(1'b0, 3'b010, 4'hA);
    a_expect("gated", 4'b1111, 1'b1, 3'd3, 1'b0);

    for (int i = 0; i < 9; i++) begin
      a_op(1'b1, 3'b001, 4'(i + 1));
      check_eq("sat_loop.count", 32'(a_cnt), (3 + i + 1 > 7) ? 32'd7 : 32'(3 + i + 1));
      check_eq("sat_loop.sat", 32'(a_sat), (3 + i + 1 >= 7) ? 32'd1 : 32'd0);
    end
    a_expect("sat", 4'h9, 1'b0, 3'd7, 1'b1);
    a_op(1'b1, 3'b000, 4'h3);    a_expect("hold_sat", 4'h9, 1'b0, 3'd7, 1'b1);
    a_op(1'b1, 3'b111, 4'h3);    a_expect("clr_sat",  4'h0, 1'b0, 3'd0, 1'b0);
    a_op(1'b0, 3'b000, 4'h0);

    // Random soak on the default-parameter instance.
    m_data = 8'h00; m_carry = 1'b0; m_cnt = 8'h00;
    for (int i = 0; i < 100; i++) begin
      logic       v;
      logic [2:0] c;
      logic [7:0] d;
      logic [7:0] prev_cnt;
      v = 1'($urandom_range(0, 3) != 0);
      c = 3'($urandom_range(0, 7));
      d = 8'($urandom);
      prev_cnt = b_cnt;
      @(negedge clk);
      b_valid = v; b_ctl = c; b_din = d;
      @(posedge clk);
      #1;
      if (v) model_step(c, d);
      check_eq("soak.data", 32'(b_dout), 32'(m_data));
      check_eq("soak.carry", 32'(b_carry), 32'(m_carry));
      check_eq("soak.count", 32'(b_cnt), 32'(m_cnt));
      check_eq("soak.sat", 32'(b_sat), (m_cnt == 8'hFF) ? 32'd1 : 32'd0);
      check_eq("soak.monotonic", 32'((b_cnt >= prev_cnt) || (v && c == 3'b111)), 32'd1);
    end
    b_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
